// File: rtl/ddr2_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ddr2_burst_ctrl
//
// Adapter between user/loopback logic and the MIG DDR2 user interface.
// A 64-bit write request becomes one write command plus two 32-bit
// write-data beats. A read request becomes one read command. The two
// 32-bit beats returned for each read are packed into a 64-bit word and
// stored in a small return FIFO. Reads are limited by a credit counter, so
// the FIFO always has room for every burst in flight. This matters because
// MIG read data cannot be stalled.
//
// Ports
//   s_clk, s_rst          clock, synchronous active-high reset
//   s_phy_init_done       MIG calibration complete; gates all acceptance
//   wr_valid/wr_ready     64-bit write request handshake (wr_addr, wr_data)
//   rd_req_valid/ready    read request handshake (rd_req_addr)
//   rd_valid/rd_ready     return FIFO output handshake (rd_data)
//   rd_credits            free read credits
//   err_unexpected_rd     sticky: a read beat arrived with nothing in flight
//   s_app_af_*            MIG command FIFO (afull in, wren/cmd/addr out)
//   s_app_wdf_*           MIG write-data FIFO (afull in, wren/data/mask out)
//   s_app_rd_data*        MIG read data beats
// ---------------------------------------------------------------------------
module ddr2_burst_ctrl #(
   parameter int ADDR_WIDTH = 31,
   parameter int RD_CREDITS = 4,
   parameter int CW         = $clog2(RD_CREDITS + 1)
) (
   input  logic                  s_clk,
   input  logic                  s_rst,
   input  logic                  s_phy_init_done,

   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [63:0]           wr_data,

   input  logic                  rd_req_valid,
   output logic                  rd_req_ready,
   input  logic [ADDR_WIDTH-1:0] rd_req_addr,

   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [63:0]           rd_data,
   output logic [CW-1:0]         rd_credits,
   output logic                  err_unexpected_rd,

   input  logic                  s_app_af_afull,
   input  logic                  s_app_wdf_afull,
   output logic                  s_app_af_wren,
   output logic [2:0]            s_app_af_cmd,
   output logic [ADDR_WIDTH-1:0] s_app_af_addr,
   output logic                  s_app_wdf_wren,
   output logic [31:0]           s_app_wdf_data,
   output logic [3:0]            s_app_wdf_mask_data,
   input  logic                  s_app_rd_data_valid,
   input  logic [31:0]           s_app_rd_data
);

   localparam int             PW       = $clog2(RD_CREDITS);
   localparam logic [CW-1:0]  CRED_MAX = CW'(RD_CREDITS);
   localparam logic [2:0]     CMD_WR   = 3'b000;
   localparam logic [2:0]     CMD_RD   = 3'b001;

   typedef enum logic {
      IDLE  = 1'b0,
      WR_HI = 1'b1
   } state_t;

   state_t                state_q,     state_d;
   logic                  last_wr_q,   last_wr_d;   // 1: last grant was a write
   logic                  af_wren_q,   af_wren_d;
   logic [2:0]            af_cmd_q,    af_cmd_d;
   logic [ADDR_WIDTH-1:0] af_addr_q,   af_addr_d;
   logic                  wdf_wren_q,  wdf_wren_d;
   logic [31:0]           wdf_data_q,  wdf_data_d;
   logic [31:0]           hi_data_q,   hi_data_d;   // high beat parked for WR_HI
   logic [CW-1:0]         credits_q,   credits_d;
   logic                  phase_q,     phase_d;     // 0: expecting low beat
   logic [31:0]           lo_beat_q,   lo_beat_d;
   logic                  err_q,       err_d;
   logic [PW-1:0]         wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0]         count_q,     count_d;

   logic [63:0]           fifo_mem [RD_CREDITS];

   logic wr_ok;
   logic rd_ok;
   logic wr_acc;
   logic rd_acc;
   logic push;
   logic pop;
   logic none_outstanding;

   // Eligibility ignores the other requester. Arbitration then masks the
   // loser, so at most one ready is high in any cycle.
   assign wr_ok = !s_rst && (state_q == IDLE) && s_phy_init_done &&
                  !s_app_af_afull && !s_app_wdf_afull;
   assign rd_ok = !s_rst && (state_q == IDLE) && s_phy_init_done &&
                  !s_app_af_afull && (credits_q != '0);

   // Round-robin: when both are eligible and valid, the type not granted
   // last wins.
   assign wr_ready     = wr_ok && (!(rd_req_valid && rd_ok) || !last_wr_q);
   assign rd_req_ready = rd_ok && (!(wr_valid && wr_ok) || last_wr_q);

   assign wr_acc = wr_valid && wr_ready;
   assign rd_acc = rd_req_valid && rd_req_ready;

   assign rd_valid = !s_rst && (count_q != '0);
   assign rd_data  = fifo_mem[rd_ptr_q];
   assign pop      = rd_valid && rd_ready;

   // The full check only protects against a misbehaving MIG. Credits
   // already guarantee space for every legitimate burst.
   assign push = !s_rst && s_app_rd_data_valid && phase_q && (count_q != CRED_MAX);

   // Bursts in flight = RD_CREDITS - credits - count. Compare a widened sum
   // so that stray pushes (sum above RD_CREDITS) also count as none.
   assign none_outstanding =
      (({1'b0, credits_q} + {1'b0, count_q}) >= (CW + 1)'(RD_CREDITS));

   assign rd_credits          = credits_q;
   assign err_unexpected_rd   = err_q;
   assign s_app_af_wren       = af_wren_q;
   assign s_app_af_cmd        = af_cmd_q;
   assign s_app_af_addr       = af_addr_q;
   assign s_app_wdf_wren      = wdf_wren_q;
   assign s_app_wdf_data      = wdf_data_q;
   assign s_app_wdf_mask_data = 4'b0000;

   always_comb begin
      state_d    = state_q;
      last_wr_d  = last_wr_q;
      af_wren_d  = 1'b0;
      af_cmd_d   = af_cmd_q;
      af_addr_d  = af_addr_q;
      wdf_wren_d = 1'b0;
      wdf_data_d = wdf_data_q;
      hi_data_d  = hi_data_q;

      case (state_q)
         IDLE: begin
            if (wr_acc) begin
               af_wren_d  = 1'b1;
               af_cmd_d   = CMD_WR;
               af_addr_d  = wr_addr;
               wdf_wren_d = 1'b1;
               wdf_data_d = wr_data[31:0];
               hi_data_d  = wr_data[63:32];
               last_wr_d  = 1'b1;
               state_d    = WR_HI;
            end else if (rd_acc) begin
               af_wren_d  = 1'b1;
               af_cmd_d   = CMD_RD;
               af_addr_d  = rd_req_addr;
               last_wr_d  = 1'b0;
            end
         end
         WR_HI: begin
            // The high beat is always sent, whatever afull or init_done do.
            wdf_wren_d = 1'b1;
            wdf_data_d = hi_data_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      phase_d   = phase_q;
      lo_beat_d = lo_beat_q;
      if (s_app_rd_data_valid) begin
         phase_d = !phase_q;
         if (!phase_q) begin
            lo_beat_d = s_app_rd_data;
         end
      end

      err_d = err_q | (s_app_rd_data_valid && none_outstanding);

      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);

      // Pop refunds a credit, but never past the maximum.
      credits_d = credits_q - CW'(rd_acc) + CW'(pop && (credits_q != CRED_MAX));
   end

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state_q    <= IDLE;
         last_wr_q  <= 1'b0;
         af_wren_q  <= 1'b0;
         af_cmd_q   <= 3'b000;
         af_addr_q  <= '0;
         wdf_wren_q <= 1'b0;
         wdf_data_q <= '0;
         hi_data_q  <= '0;
         credits_q  <= CRED_MAX;
         phase_q    <= 1'b0;
         lo_beat_q  <= '0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_wr_q  <= last_wr_d;
         af_wren_q  <= af_wren_d;
         af_cmd_q   <= af_cmd_d;
         af_addr_q  <= af_addr_d;
         wdf_wren_q <= wdf_wren_d;
         wdf_data_q <= wdf_data_d;
         hi_data_q  <= hi_data_d;
         credits_q  <= credits_d;
         phase_q    <= phase_d;
         lo_beat_q  <= lo_beat_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
      if (push) begin
         fifo_mem[wr_ptr_q] <= {s_app_rd_data, lo_beat_q};
      end
   end

endmodule

// File: doc/ddr2_burst_ctrl.md
Name: ddr2_burst_ctrl

Overview:
MIG DDR2 user-interface adapter that sits directly downstream of the loopback/user logic and drives the controller app_af/app_wdf/rd_data ports on its behalf.
- Accepts 64-bit write requests and read requests over valid/ready handshakes.
- Splits each write into one command plus two 32-bit write-data beats, honouring af_afull and wdf_afull.
- Packs returned 32-bit read beats into 64-bit words in a credit-protected return FIFO, so MIG read data, which cannot be stalled, never overflows.

Parameters:
- ADDR_WIDTH, 31, width of the MIG command address.
- RD_CREDITS, 4, maximum outstanding read bursts; also the return FIFO depth in 64-bit entries. Must be a power of 2, at least 2.
- CW, $clog2(RD_CREDITS+1), width of the credit counter (derived; not overridden).

Ports:
- s_clk  in  1  system clock
- s_rst  in  1  reset
- s_phy_init_done  in  1  MIG calibration complete
- wr_valid  in  1  write request present
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_WIDTH  write burst address
- wr_data  in  64  write data; [31:0] is beat 0
- rd_req_valid  in  1  read request present
- rd_req_ready  out  1  read request accepted this cycle
- rd_req_addr  in  ADDR_WIDTH  read burst address
- rd_valid  out  1  return FIFO not empty
- rd_ready  in  1  consumer takes rd_data
- rd_data  out  64  head of return FIFO; [31:0] is first beat
- rd_credits  out  CW  free read credits
- err_unexpected_rd  out  1  sticky: read beat arrived with nothing outstanding
- s_app_af_afull  in  1  MIG address FIFO almost full
- s_app_wdf_afull  in  1  MIG write-data FIFO almost full
- s_app_af_wren  out  1  command strobe
- s_app_af_cmd  out  3  000 write, 001 read
- s_app_af_addr  out  ADDR_WIDTH  command address
- s_app_wdf_wren  out  1  write-data strobe
- s_app_wdf_data  out  32  write-data beat
- s_app_wdf_mask_data  out  4  tied to 4'b0000
- s_app_rd_data_valid  in  1  read beat valid
- s_app_rd_data  in  32  read beat

Behaviour:
- Reset: s_rst is a synchronous, active-high reset on clock s_clk. While it is asserted:
  - af_wren, wdf_wren, af_cmd, af_addr, wdf_data are all 0.
  - wr_ready = rd_req_ready = 0.
  - FSM returns to IDLE; FIFO is emptied so rd_valid = 0; rd_credits = RD_CREDITS.
  - Beat phase = 0; err_unexpected_rd = 0.
  - A burst in progress is abandoned; no second beat is issued.
- FSM states: IDLE and WR_HI.
- wr_ready and rd_req_ready are combinational and are 1 only in IDLE when all acceptance conditions hold. A request is accepted on a clock edge where valid and ready are both 1.
- Write acceptance conditions: phy_init_done, !af_afull, !wdf_afull.
- Read acceptance conditions: phy_init_done, !af_afull, rd_credits != 0.
- Arbitration: at most one request is accepted per cycle.
  - If both requests are eligible, grant round-robin: the type not granted last wins.
  - Last-grant register resets to "read", so the first contested grant goes to write.
- Write accepted at edge N:
  - Cycle N+1: af_wren = 1, af_cmd = 000, af_addr = wr_addr, wdf_wren = 1, wdf_data = wr_data[31:0]; state = WR_HI.
  - Cycle N+2: wdf_wren = 1, wdf_data = wr_data[63:32], af_wren = 0; state returns to IDLE.
  - Peak write rate is one write per 2 cycles.
  - WR_HI always completes, even if afull or phy_init_done changes.
- Read accepted at edge N:
  - Cycle N+1: af_wren = 1, af_cmd = 001, af_addr = rd_req_addr.
  - Credit is decremented.
  - Back-to-back reads may be accepted every cycle.
- Strobes are single-cycle. af_cmd, af_addr and wdf_data hold their last value when strobes are low.
- Read return:
  - Beat phase toggles on each s_app_rd_data_valid.
  - Phase 0 stores the low half; phase 1 pushes {beat1, beat0} into the FIFO.
  - A pushed word appears on rd_valid the cycle after the second beat.
- Pop on rd_valid & rd_ready.
- Credits:
  - Acceptance alone gives -1; pop alone gives +1; both in the same cycle leave the count unchanged.
  - Credit count never exceeds RD_CREDITS; the FIFO therefore cannot overflow.
- Error flag: if a beat arrives while outstanding reads (RD_CREDITS − rd_credits − FIFO count) = 0, set err_unexpected_rd. It is cleared only by reset.
- phy_init_done low: no acceptance; data already in the FIFO still drains.

Test Plan:
- Write, 64-bit data (0xDEADBEEF_01234567 at 0x40) → cycle N+1: af_wren, cmd 000, addr 0x40, wdf 0x01234567. Cycle N+2: wdf 0xDEADBEEF. wr_ready high for 1 cycle.
- Read, then MIG returns 0x11111111 then 0x22222222 → rd_valid with rd_data = 0x22222222_11111111. rd_credits goes 4→3, then back to 4 after pop.
- Credit exhaustion: 4 reads issued with rd_ready = 0 → 5th read request is stalled (rd_req_ready = 0). Popping one entry re-enables it next cycle.
- Flow control: wdf_afull = 1 with write pending → no write accepted, while a pending read is still accepted. af_afull = 1 → nothing accepted.
- Contention: wr_valid and rd_req_valid held high for 8 grants → alternating write, read, write…; first grant is write.
- Reset asserted in WR_HI → next cycle all strobes 0, no high beat emitted, rd_credits = 4. A stray read beat after reset sets err_unexpected_rd.
